ray_sphere_discriminant: RTL
============================

// Module: ray_sphere_discriminant
// PURPOSE
//  Downstream consumer of the signed dot-product pipeline in the ray-sphere hit path.
//  Takes b = D.OC and OC.OC from the dot-product stages, plus r^2, and computes
//  disc = b*b - (OC.OC - r^2) through a 3-stage valid/ready pipeline.
//  Emits a saturated discriminant, a hit flag and a ray tag, and keeps hit/miss statistics.
// PARAMETERS
//  W      19  width of all signed fixed-point data (matches dot-product scalar width)
//  FRAC   8   fractional bits of the fixed-point format
//  TAG_W  4   width of the ray tag carried alongside the data
//  CNT_W  16  width of the hit/miss statistics counters
// PORTS
//  clk         in   1      clock; all logic on rising edge
//  rst_n       in   1      synchronous active-low reset
//  s_valid     in   1      input word valid
//  s_ready     out  1      block can accept an input this cycle (combinational)
//  s_b         in   W      b = D.OC, signed
//  s_oc_sq     in   W      OC.OC, signed
//  s_r_sq      in   W      sphere radius squared, signed
//  s_tag       in   TAG_W  ray identifier, passed through unchanged
//  m_valid     out  1      output word valid
//  m_ready     in   1      downstream accepts output
//  m_disc      out  W      saturated discriminant, signed
//  m_hit       out  1      1 when the unsaturated discriminant is >= 0
//  m_tag       out  TAG_W  tag of the output word
//  hit_count   out  CNT_W  number of accepted outputs with m_hit=1
//  miss_count  out  CNT_W  number of accepted outputs with m_hit=0
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): all stage valids, m_valid, m_disc, m_hit, m_tag and both counters go to 0.
//    In-flight words are discarded and are not counted. s_ready=1 in the first cycle after reset.
//  - Pipeline: S1 registers the inputs. S2 computes bb = (b*b)>>>FRAC (2W-bit product) and c = oc_sq - r_sq (W+1 bits).
//    S3 is the output register: d = bb - c at full width; m_hit = (d >= 0); m_disc = d clamped to [-2^(W-1), 2^(W-1)-1].
//  - Latency: with no stall, a word accepted at edge N appears with m_valid=1 after edge N+2, i.e. 3 register stages.
//  - Flow control: S3 advances when !m_valid || m_ready. Stage k advances when it is empty or stage k+1 advances.
//    s_ready = !v1 || adv1. Empty stages are filled, so bubbles collapse. Full throughput is 1 word per cycle.
//  - Handshakes: input transfer happens on s_valid && s_ready; output transfer on m_valid && m_ready.
//    Input data is ignored when s_valid=0. While m_valid && !m_ready, m_disc, m_hit and m_tag hold stable.
//  - Data registers load only when their stage advances. Word order is preserved.
//  - Counters: on each output transfer, hit_count increments if m_hit, otherwise miss_count increments.
//    Both wrap modulo 2^CNT_W with no sticky flag.
//  - Simultaneous events: an input accept and an output transfer in the same cycle are both performed.
//    Reset overrides every handshake.
// TESTING
//  1 b=512, oc_sq=1280, r_sq=256 -> bb=1024, c=1024: 3 edges later m_valid=1, m_disc=0, m_hit=1.
//  2 b=256, oc_sq=2304, r_sq=256 -> m_disc=-1792 (19'h7F900), m_hit=0, miss_count=1.
//  3 b=19'h3FFFF, oc_sq=0, r_sq=0 -> m_disc saturates to 19'h3FFFF, m_hit=1.
//    Also b=0, oc_sq=19'h3FFFF, r_sq=19'h40000 -> d=-524287, m_disc=19'h40000, m_hit=0.
//  4 Tags 0..4 sent back-to-back, m_ready=0 for 4 cycles once m_valid rises:
//    s_ready drops after 3 words are held, m_disc/m_tag stay stable, all 5 tags exit in order, none lost or duplicated.
//  5 3 hits + 2 misses -> hit_count=3, miss_count=2. With CNT_W=4, 17 hits -> hit_count=1 (wrap).
//  6 rst_n=0 for 1 cycle with 2 words in flight -> next cycle m_valid=0, counters=0, s_ready=1.
//    No stale output ever appears.

Source files
------------

// File: rtl/ray_sphere_discriminant.sv
// ray_sphere_discriminant
//   Final stage of the ray-sphere hit path. Computes
//   disc = ((b*b) >>> FRAC) - (oc_sq - r_sq) through three valid/ready
//   register stages. Emits a saturated discriminant, a hit flag and the ray tag,
//   and keeps wrapping hit/miss counters.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   s_valid/s_ready   input handshake (s_ready is combinational)
//   s_b, s_oc_sq,     signed W-bit operands: b = D.OC, OC.OC, radius^2
//   s_r_sq
//   s_tag             ray identifier, passed through unchanged
//   m_valid/m_ready   output handshake
//   m_disc            signed W-bit discriminant clamped to the W-bit range
//   m_hit             1 when the unclamped discriminant is >= 0
//   m_tag             tag of the output word
//   hit_count,        counts of accepted outputs with m_hit=1 / m_hit=0
//   miss_count
module ray_sphere_discriminant #(
    parameter int unsigned W     = 19,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_b,
    input  logic [W-1:0]     s_oc_sq,
    input  logic [W-1:0]     s_r_sq,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_disc,
    output logic             m_hit,
    output logic [TAG_W-1:0] m_tag,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int unsigned PW = 2 * W;      // full product width
    localparam int unsigned DW = 2 * W + 1;  // difference width, cannot overflow

    localparam logic signed [DW-1:0] DMAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [DW-1:0] DMIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

    // Stage 1: registered inputs
    logic                    v1_q;
    logic signed [W-1:0]     b1_q, oc1_q, r1_q;
    logic [TAG_W-1:0]        tag1_q;

    // Stage 2: scaled square and c term
    logic                    v2_q;
    logic signed [PW-1:0]    bb2_q;
    logic signed [W:0]       c2_q;
    logic [TAG_W-1:0]        tag2_q;

    logic                    adv1, adv2, adv3;
    logic signed [PW-1:0]    bx, prod, bb_d;
    logic signed [W:0]       c_d;
    logic signed [DW-1:0]    d_d;
    logic [W-1:0]            disc_d;
    logic                    hit_d;

    always_comb begin
        adv3    = !m_valid || m_ready;
        adv2    = !v2_q || adv3;
        adv1    = !v1_q || adv2;
        s_ready = adv1;

        bx   = {{W{b1_q[W-1]}}, b1_q};
        prod = bx * bx;
        bb_d = prod >>> FRAC;
        c_d  = {oc1_q[W-1], oc1_q} - {r1_q[W-1], r1_q};

        d_d   = {bb2_q[PW-1], bb2_q} - {{W{c2_q[W]}}, c2_q};
        hit_d = !d_d[DW-1];
        if (d_d > DMAX) begin
            disc_d = {1'b0, {(W - 1){1'b1}}};
        end else if (d_d < DMIN) begin
            disc_d = {1'b1, {(W - 1){1'b0}}};
        end else begin
            disc_d = d_d[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            b1_q       <= '0;
            oc1_q      <= '0;
            r1_q       <= '0;
            tag1_q     <= '0;
            v2_q       <= 1'b0;
            bb2_q      <= '0;
            c2_q       <= '0;
            tag2_q     <= '0;
            m_valid    <= 1'b0;
            m_disc     <= '0;
            m_hit      <= 1'b0;
            m_tag      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (adv1) begin
                v1_q <= s_valid;
                if (s_valid) begin
                    b1_q   <= s_b;
                    oc1_q  <= s_oc_sq;
                    r1_q   <= s_r_sq;
                    tag1_q <= s_tag;
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    bb2_q  <= bb_d;
                    c2_q   <= c_d;
                    tag2_q <= tag1_q;
                end
            end
            // Output registers only change on advance, so they hold under stall
            if (adv3) begin
                m_valid <= v2_q;
                if (v2_q) begin
                    m_disc <= disc_d;
                    m_hit  <= hit_d;
                    m_tag  <= tag2_q;
                end
            end
            if (m_valid && m_ready) begin
                if (m_hit) begin
                    hit_count <= hit_count + CNT_W'(1);
                end else begin
                    miss_count <= miss_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
